// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating stall counter. One slot, one cycle of latency.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        IF_ID_reg_rs,
  input  logic [4:0]        IF_ID_reg_rt,
  input  logic [4:0]        IF_ID_reg_rd,
  input  logic [DATA_W-1:0] ID_read_data1,
  input  logic [DATA_W-1:0] ID_read_data2,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic              ID_regWrite,
  input  logic              ID_memRead,
  input  logic              ID_memWrite,
  input  logic              ID_memToReg,
  input  logic              ID_aluSrc,
  input  logic              ID_regDst,
  input  logic [3:0]        ID_aluOp,
  input  logic              ID_valid,
  input  logic              branch_taken,
  output logic [4:0]        ID_EX_reg_rs,
  output logic [4:0]        ID_EX_reg_rt,
  output logic [4:0]        ID_EX_write_reg,
  output logic [DATA_W-1:0] ID_EX_data1,
  output logic [DATA_W-1:0] ID_EX_data2,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic              EX_regWrite,
  output logic              EX_memRead,
  output logic              EX_memWrite,
  output logic              EX_memToReg,
  output logic              EX_aluSrc,
  output logic [3:0]        EX_aluOp,
  output logic              ID_EX_valid,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic bubble;

  // A store matching only on rt is excluded: its store data is forwarded later.
  assign rs_hit   = (ID_EX_write_reg == IF_ID_reg_rs);
  assign rt_hit   = (ID_EX_write_reg == IF_ID_reg_rt) && !ID_memWrite;
  assign load_use = ID_EX_valid && EX_memRead && (ID_EX_write_reg != 5'd0) &&
                    ID_valid && (rs_hit || rt_hit);

  assign stall       = load_use && !branch_taken;
  assign pc_write    = !stall;
  assign IF_ID_write = !stall;
  assign bubble      = branch_taken || stall;

  // ID -> EX slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ID_EX_valid     <= 1'b0;
      ID_EX_reg_rs    <= '0;
      ID_EX_reg_rt    <= '0;
      ID_EX_write_reg <= '0;
      ID_EX_data1     <= '0;
      ID_EX_data2     <= '0;
      ID_EX_imm       <= '0;
      EX_regWrite     <= 1'b0;
      EX_memRead      <= 1'b0;
      EX_memWrite     <= 1'b0;
      EX_memToReg     <= 1'b0;
      EX_aluSrc       <= 1'b0;
      EX_aluOp        <= '0;
    end else if (bubble) begin
      ID_EX_valid     <= 1'b0;
      ID_EX_reg_rs    <= '0;
      ID_EX_reg_rt    <= '0;
      ID_EX_write_reg <= '0;
      ID_EX_data1     <= '0;
      ID_EX_data2     <= '0;
      ID_EX_imm       <= '0;
      EX_regWrite     <= 1'b0;
      EX_memRead      <= 1'b0;
      EX_memWrite     <= 1'b0;
      EX_memToReg     <= 1'b0;
      EX_aluSrc       <= 1'b0;
      EX_aluOp        <= '0;
    end else begin
      ID_EX_valid     <= ID_valid;
      ID_EX_reg_rs    <= IF_ID_reg_rs;
      ID_EX_reg_rt    <= IF_ID_reg_rt;
      ID_EX_write_reg <= ID_regDst ? IF_ID_reg_rd : IF_ID_reg_rt;
      ID_EX_data1     <= ID_read_data1;
      ID_EX_data2     <= ID_read_data2;
      ID_EX_imm       <= ID_imm;
      EX_regWrite     <= ID_regWrite & ID_valid;
      EX_memRead      <= ID_memRead & ID_valid;
      EX_memWrite     <= ID_memWrite & ID_valid;
      EX_memToReg     <= ID_memToReg & ID_valid;
      EX_aluSrc       <= ID_aluSrc & ID_valid;
      EX_aluOp        <= ID_aluOp & {4{ID_valid}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a slot-level behavioural model,
// with directed hazard, flush, register-zero, saturation and reset scenarios.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs, rt, rd;
  logic [DW-1:0] d1, d2, imm;
  logic regWrite, memRead, memWrite, memToReg, aluSrc, regDst, valid, branch;
  logic [3:0] aluOp;
  logic [4:0] o_rs, o_rt, o_wr;
  logic [DW-1:0] o_d1, o_d2, o_imm;
  logic o_regWrite, o_memRead, o_memWrite, o_memToReg, o_aluSrc, o_valid;
  logic [3:0] o_aluOp;
  logic pc_write, if_id_write, stall;
  logic [CW-1:0] stall_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_reg_rs(rs), .IF_ID_reg_rt(rt), .IF_ID_reg_rd(rd),
    .ID_read_data1(d1), .ID_read_data2(d2), .ID_imm(imm),
    .ID_regWrite(regWrite), .ID_memRead(memRead), .ID_memWrite(memWrite),
    .ID_memToReg(memToReg), .ID_aluSrc(aluSrc), .ID_regDst(regDst),
    .ID_aluOp(aluOp), .ID_valid(valid), .branch_taken(branch),
    .ID_EX_reg_rs(o_rs), .ID_EX_reg_rt(o_rt), .ID_EX_write_reg(o_wr),
    .ID_EX_data1(o_d1), .ID_EX_data2(o_d2), .ID_EX_imm(o_imm),
    .EX_regWrite(o_regWrite), .EX_memRead(o_memRead), .EX_memWrite(o_memWrite),
    .EX_memToReg(o_memToReg), .EX_aluSrc(o_aluSrc), .EX_aluOp(o_aluOp),
    .ID_EX_valid(o_valid), .pc_write(pc_write), .IF_ID_write(if_id_write),
    .stall(stall), .stall_count(stall_count)
  );

  // Model: what instruction sits in the EX slot, plus the stall tally.
  logic m_valid;
  logic [4:0] m_rs, m_rt, m_wr;
  logic [DW-1:0] m_d1, m_d2, m_imm;
  logic [4:0] m_ctrl;
  logic [3:0] m_op;
  int m_cnt;

  function automatic logic model_stall();
    logic hit;
    hit = (m_wr == rs) || ((m_wr == rt) && !memWrite);
    return m_valid && m_ctrl[3] && (m_wr != 0) && valid && hit && !branch;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rs = 0; m_rt = 0; m_wr = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0; m_op = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
      m_cnt = 0;
    end else if (branch) begin
      model_clear();
    end else if (model_stall()) begin
      model_clear();
      m_cnt = (m_cnt == 3) ? 3 : m_cnt + 1;
    end else begin
      m_valid = valid;
      m_rs = rs; m_rt = rt;
      m_wr = regDst ? rd : rt;
      m_d1 = d1; m_d2 = d2; m_imm = imm;
      m_ctrl = valid ? {regWrite, memRead, memWrite, memToReg, aluSrc} : 5'b0;
      m_op = valid ? aluOp : 4'b0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic s;
    s = model_stall();
    check("stall", 128'(stall), 128'(s));
    check("pc_write", 128'(pc_write), 128'(!s));
    check("IF_ID_write", 128'(if_id_write), 128'(!s));
    check("stall_count", 128'(stall_count), 128'(m_cnt));
    check("slot", {o_valid, o_rs, o_rt, o_wr, o_d1, o_d2, o_imm,
                   o_regWrite, o_memRead, o_memWrite, o_memToReg, o_aluSrc, o_aluOp},
                  {m_valid, m_rs, m_rt, m_wr, m_d1, m_d2, m_imm, m_ctrl, m_op});
  end

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic dst, input logic mr, input logic mw, input logic br);
    rs = a; rt = b; rd = c; regDst = dst; memRead = mr; memWrite = mw;
    branch = br; valid = 1; regWrite = !mw; memToReg = mr; aluSrc = mr | mw;
    aluOp = 4'h2; d1 = $urandom; d2 = $urandom; imm = $urandom;
  endtask

  task automatic rand_inputs(input logic hold);
    if (!hold) begin
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3)); regDst = 1'($urandom);
      memRead = ($urandom_range(0, 2) == 0); memWrite = 1'($urandom);
      regWrite = 1'($urandom); memToReg = 1'($urandom); aluSrc = 1'($urandom);
      aluOp = 4'($urandom); valid = ($urandom_range(0, 4) != 0);
      d1 = $urandom; d2 = $urandom; imm = $urandom;
    end
    branch = ($urandom_range(0, 9) == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic held;
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(o_valid), 0);
    check("rst_count", 128'(stall_count), 0);
    check("rst_stall", 128'(stall), 0);
    check("rst_pc_write", 128'(pc_write), 1);
    check("rst_if_id_write", 128'(if_id_write), 1);
    check("rst_data1", 128'(o_d1), 0);
    reset = 0;

    // load r5 then dependent add on rs
    drive(1, 5, 9, 0, 1, 0, 0);
    tick();
    check("lw_wr", 128'(o_wr), 5);
    check("lw_memread", 128'(o_memRead), 1);
    drive(5, 6, 7, 1, 0, 0, 0);
    #1;
    check("lu_stall", 128'(stall), 1);
    check("lu_pc_write", 128'(pc_write), 0);
    check("lu_if_id_write", 128'(if_id_write), 0);
    tick();
    check("lu_bubble", 128'(o_valid), 0);
    check("lu_count", 128'(stall_count), 1);
    check("lu_no_restall", 128'(stall), 0);
    tick();
    check("lu_add_valid", 128'(o_valid), 1);
    check("lu_add_wr", 128'(o_wr), 7);
    check("lu_add_rs", 128'(o_rs), 5);

    // store data match on rt only
    drive(1, 5, 9, 0, 1, 0, 0);
    tick();
    drive(2, 5, 0, 0, 0, 1, 0);
    #1;
    check("sw_stall", 128'(stall), 0);
    tick();
    check("sw_valid", 128'(o_valid), 1);
    check("sw_memwrite", 128'(o_memWrite), 1);
    check("sw_rt", 128'(o_rt), 5);

    // hazard masked by branch
    drive(1, 5, 9, 0, 1, 0, 0);
    tick();
    drive(5, 6, 7, 1, 0, 0, 1);
    #1;
    check("br_stall", 128'(stall), 0);
    check("br_pc_write", 128'(pc_write), 1);
    tick();
    check("br_bubble", 128'(o_valid), 0);
    check("br_regwrite", 128'(o_regWrite), 0);
    check("br_count", 128'(stall_count), 1);

    // load into r0
    drive(1, 0, 9, 0, 1, 0, 0);
    tick();
    check("r0_wr", 128'(o_wr), 0);
    drive(0, 0, 3, 1, 0, 0, 0);
    #1;
    check("r0_stall", 128'(stall), 0);
    tick();
    check("r0_valid", 128'(o_valid), 1);
    check("r0_rs", 128'(o_rs), 0);

    // asynchronous reset between edges
    #2;
    reset = 1;
    #1;
    check("arst_valid", 128'(o_valid), 0);
    check("arst_wr", 128'(o_wr), 0);
    check("arst_data1", 128'(o_d1), 0);
    check("arst_count", 128'(stall_count), 0);
    #1;
    reset = 0;
    tick();
    check("arst_resume_valid", 128'(o_valid), 1);
    check("arst_resume_wr", 128'(o_wr), 3);

    // saturation with a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      drive(1, 5, 9, 0, 1, 0, 0);
      tick();
      drive(5, 6, 7, 1, 0, 0, 0);
      #1;
      check("sat_stall", 128'(stall), 1);
      tick();
      check("sat_count", 128'(stall_count), 128'((k < 2) ? k + 1 : 3));
      tick();
    end

    held = 0;
    for (int i = 0; i < 600; i++) begin
      rand_inputs(held);
      #1;
      held = model_stall();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
